dma_job_sequencer: RTL and testbench



---
 rtl/dma_job_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_job_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dma_job_sequencer
// Description : Walks the bank1 job table from slot 0 to the latched end
//               slot. For each slot it steps the DMA configuration writer
//               through its one-hot register writes and waits for both DMA
//               channels to complete. It then writes status and cycle count
//               back to the slot. A level abort finishes any in-flight
//               config step, writes an aborted status and stops the walk.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_job_sequencer #(
    parameter int BANK1_INDEX_WIDTH   = 3,
    parameter int BANK1_STATUS_WIDTH  = 2,
    parameter int BANK1_PROFILE_WIDTH = 32,
    parameter int BANK0_CONTROL_WIDTH = 4,
    parameter int BANK0_STATUS_WIDTH  = 4,
    parameter int BANK0_CNT_WIDTH     = BANK1_INDEX_WIDTH,
    parameter int DMA_INIT_TASK_CNT   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BANK0_CONTROL_WIDTH-1:0] ext_bank0_out_control,
    input  logic [BANK0_CNT_WIDTH-1:0]     ext_bank0_out_endCnt,
    output logic [BANK0_STATUS_WIDTH-1:0]  ext_bank0_in_status,
    output logic [BANK0_CNT_WIDTH-1:0]     ext_bank0_in_cnt,
    output logic [BANK0_CNT_WIDTH-1:0]     slot_idx,
    output logic [DMA_INIT_TASK_CNT-1:0]   slaveInit,
    input  logic [DMA_INIT_TASK_CNT-1:0]   slaveFinInit,
    input  logic                           dma_mm2s_done,
    input  logic                           dma_s2mm_done,
    output logic                           slot_wr_en,
    output logic [BANK1_STATUS_WIDTH-1:0]  slot_wr_status,
    output logic [BANK1_PROFILE_WIDTH-1:0] slot_wr_profile
);

    // Slot status codes written back to bank1
    localparam logic [BANK1_STATUS_WIDTH-1:0] c_ST_DONE    = BANK1_STATUS_WIDTH'(2'b10);
    localparam logic [BANK1_STATUS_WIDTH-1:0] c_ST_ABORTED = BANK1_STATUS_WIDTH'(2'b11);

    // First config-writer step and all-ones profile value
    localparam logic [DMA_INIT_TASK_CNT-1:0]   c_FIRST_STEP = DMA_INIT_TASK_CNT'(1);
    localparam logic [BANK1_PROFILE_WIDTH-1:0] c_PROF_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WB        = 3'd3,
        S_FIN       = 3'd4
    } state_t;

    state_t                         state_q,     state_d;
    logic [BANK0_CNT_WIDTH-1:0]     end_cnt_q,   end_cnt_d;
    logic [BANK0_CNT_WIDTH-1:0]     slot_idx_q,  slot_idx_d;
    logic [DMA_INIT_TASK_CNT-1:0]   slv_init_q,  slv_init_d;
    logic                           mm2s_f_q,    mm2s_f_d;
    logic                           s2mm_f_q,    s2mm_f_d;
    logic [BANK1_PROFILE_WIDTH-1:0] profile_q,   profile_d;
    logic                           done_q,      done_d;
    logic                           aborted_q,   aborted_d;
    logic                           abort_req_q, abort_req_d;
    logic [BANK1_STATUS_WIDTH-1:0]  wb_status_q, wb_status_d;

    logic                           w_start;
    logic                           w_abort;
    logic                           w_abort_now;
    logic                           w_step_ack;
    logic                           w_mm2s_seen;
    logic                           w_s2mm_seen;
    logic [BANK1_PROFILE_WIDTH-1:0] w_profile_inc;
    logic                           w_busy;
    logic                           w_unused_ctrl;

    // Decode the control word; only start and abort carry meaning
    always_comb begin
        w_start       = ext_bank0_out_control[0];
        w_abort       = ext_bank0_out_control[1];
        w_unused_ctrl = ^ext_bank0_out_control;
    end

    // Handshake, completion and saturating profile helpers
    always_comb begin
        w_abort_now   = abort_req_q | w_abort;
        w_step_ack    = (slaveFinInit == slv_init_q);
        w_mm2s_seen   = mm2s_f_q | dma_mm2s_done;
        w_s2mm_seen   = s2mm_f_q | dma_s2mm_done;
        w_profile_inc = (profile_q == c_PROF_MAX) ? profile_q
                                                  : profile_q + BANK1_PROFILE_WIDTH'(1);
    end

    // Next-state logic for the slot walk
    always_comb begin
        state_d     = state_q;
        end_cnt_d   = end_cnt_q;
        slot_idx_d  = slot_idx_q;
        slv_init_d  = slv_init_q;
        mm2s_f_d    = mm2s_f_q;
        s2mm_f_d    = s2mm_f_q;
        profile_d   = profile_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        abort_req_d = abort_req_q;
        wb_status_d = wb_status_q;

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    end_cnt_d   = ext_bank0_out_endCnt;
                    slot_idx_d  = '0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    abort_req_d = 1'b0;
                    slv_init_d  = c_FIRST_STEP;
                    mm2s_f_d    = 1'b0;
                    s2mm_f_d    = 1'b0;
                    profile_d   = '0;
                    state_d     = S_INIT;
                end
            end

            S_INIT: begin
                profile_d   = w_profile_inc;
                abort_req_d = w_abort_now;
                // The in-flight step always completes; abort only replaces
                // the next step with an aborted writeback.
                if (w_step_ack) begin
                    if (w_abort_now) begin
                        slv_init_d  = '0;
                        wb_status_d = c_ST_ABORTED;
                        state_d     = S_WB;
                    end else if (slv_init_q[DMA_INIT_TASK_CNT-1]) begin
                        slv_init_d  = '0;
                        state_d     = S_WAIT_DONE;
                    end else begin
                        slv_init_d  = slv_init_q << 1;
                    end
                end
            end

            S_WAIT_DONE: begin
                profile_d   = w_profile_inc;
                abort_req_d = w_abort_now;
                mm2s_f_d    = w_mm2s_seen;
                s2mm_f_d    = w_s2mm_seen;
                // Completion beats a same-cycle abort; the abort still ends
                // the walk after this writeback.
                if (w_mm2s_seen && w_s2mm_seen) begin
                    wb_status_d = c_ST_DONE;
                    state_d     = S_WB;
                end else if (w_abort_now) begin
                    wb_status_d = c_ST_ABORTED;
                    state_d     = S_WB;
                end
            end

            S_WB: begin
                if (abort_req_q || (slot_idx_q == end_cnt_q)) begin
                    done_d    = 1'b1;
                    aborted_d = abort_req_q;
                    state_d   = S_FIN;
                end else begin
                    slot_idx_d = slot_idx_q + BANK0_CNT_WIDTH'(1);
                    slv_init_d = c_FIRST_STEP;
                    mm2s_f_d   = 1'b0;
                    s2mm_f_d   = 1'b0;
                    profile_d  = '0;
                    state_d    = S_INIT;
                end
            end

            S_FIN: begin
                if (!w_start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            end_cnt_q   <= '0;
            slot_idx_q  <= '0;
            slv_init_q  <= '0;
            mm2s_f_q    <= 1'b0;
            s2mm_f_q    <= 1'b0;
            profile_q   <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abort_req_q <= 1'b0;
            wb_status_q <= '0;
        end else begin
            state_q     <= state_d;
            end_cnt_q   <= end_cnt_d;
            slot_idx_q  <= slot_idx_d;
            slv_init_q  <= slv_init_d;
            mm2s_f_q    <= mm2s_f_d;
            s2mm_f_q    <= s2mm_f_d;
            profile_q   <= profile_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            abort_req_q <= abort_req_d;
            wb_status_q <= wb_status_d;
        end
    end

    // Output mapping; writeback fields are only non-zero during the strobe
    always_comb begin
        w_busy              = (state_q == S_INIT) || (state_q == S_WAIT_DONE) ||
                              (state_q == S_WB);
        ext_bank0_in_status    = '0;
        ext_bank0_in_status[0] = w_busy;
        ext_bank0_in_status[1] = done_q;
        ext_bank0_in_status[2] = aborted_q;
        ext_bank0_in_cnt    = slot_idx_q;
        slot_idx            = slot_idx_q;
        slaveInit           = slv_init_q;
        slot_wr_en          = (state_q == S_WB);
        slot_wr_status      = (state_q == S_WB) ? wb_status_q : '0;
        slot_wr_profile     = (state_q == S_WB) ? profile_q   : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_job_sequencer
// Description : Self-checking bench for dma_job_sequencer with a config
//               writer / DMA model, directed vector table, reset sequence
//               and randomized jobs against a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_job_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  control;
    logic [2:0]  end_cnt;
    logic [3:0]  status;
    logic [2:0]  cnt_o;
    logic [2:0]  slot_idx;
    logic [7:0]  slaveInit;
    logic [7:0]  slv_fin;
    logic        mm2s;
    logic        s2mm;
    logic        wr_en;
    logic [1:0]  wr_status;
    logic [31:0] wr_profile;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Edge counter: value N seen at a negedge means N rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    dma_job_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .ext_bank0_out_control (control),
        .ext_bank0_out_endCnt  (end_cnt),
        .ext_bank0_in_status   (status),
        .ext_bank0_in_cnt      (cnt_o),
        .slot_idx              (slot_idx),
        .slaveInit             (slaveInit),
        .slaveFinInit          (slv_fin),
        .dma_mm2s_done         (mm2s),
        .dma_s2mm_done         (s2mm),
        .slot_wr_en            (wr_en),
        .slot_wr_status        (wr_status),
        .slot_wr_profile       (wr_profile)
    );

    // Job descriptor: timing knobs plus table expectations
    typedef struct {
        int       end_c;
        int       d;
        int       a;
        int       b;
        int       abort_off;
        bit       early;
        bit       noise;
        int       exp_wbs;
        logic [3:0] exp_status;
    } vec_t;

    typedef struct { int slot; int cnt; int st; int prof; int cyc; } obs_t;
    typedef struct { int slot; int st; int cyc; int prof; int steps; } exp_t;

    obs_t       obs_q[$];
    exp_t       exp_q[$];
    logic [7:0] seq_q[$];
    logic [7:0] prev_si = '0;

    // Writer / DMA model knobs
    int ack_d    = 1;
    int dly_a    = 1;
    int dly_b    = 1;
    bit early_en = 1'b0;
    bit noise_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Config writer acks each step ack_d cycles after it appears; the DMA
    // channels pulse done dly_a / dly_b cycles after the last step is acked.
    initial begin : writer_model
        int         w_cnt;
        int         ca;
        int         cb;
        logic [7:0] w_last;
        logic [7:0] bogus;
        w_cnt = 0; ca = 0; cb = 0; w_last = '0;
        slv_fin = '0; mm2s = 1'b0; s2mm = 1'b0;
        forever begin
            @(negedge clk);
            slv_fin = '0; mm2s = 1'b0; s2mm = 1'b0;
            if (!reset) begin
                w_cnt = 0; w_last = '0; ca = 0; cb = 0;
            end else begin
                if (ca > 0) begin ca--; if (ca == 0) mm2s = 1'b1; end
                if (cb > 0) begin cb--; if (cb == 0) s2mm = 1'b1; end
                if (slaveInit != 8'h00) begin
                    if (slaveInit != w_last) begin
                        w_last = slaveInit;
                        w_cnt  = 0;
                    end
                    w_cnt++;
                    if (w_cnt == ack_d) begin
                        slv_fin = slaveInit;
                        if (slaveInit == 8'h80) begin ca = dly_a; cb = dly_b; end
                        if (early_en && slaveInit == 8'h10) begin mm2s = 1'b1; s2mm = 1'b1; end
                    end else if (noise_en && $urandom_range(0, 2) == 0) begin
                        bogus = 8'($urandom);
                        if (bogus == slaveInit) bogus = ~bogus;
                        slv_fin = bogus;
                    end
                end else begin
                    w_last = '0;
                    w_cnt  = 0;
                end
            end
        end
    end

    // Capture writeback strobes and the sequence of issued config steps
    always @(negedge clk) begin
        if (wr_en === 1'b1)
            obs_q.push_back('{int'(slot_idx), int'(cnt_o), int'(wr_status),
                              int'(wr_profile), cyc});
        if (slaveInit != prev_si && slaveInit != 8'h00)
            seq_q.push_back(slaveInit);
        prev_si <= slaveInit;
    end

    // Reference timeline: slot s starts at edge I; each step takes d cycles,
    // completion needs max(a,b) cycles after config, a slot's profile is the
    // number of cycles from its start to its writeback, and the next slot
    // starts one cycle after that writeback. An abort level first seen at
    // edge A is resolved against the slot that is active at that edge.
    task automatic model(input int S, input int A, input vec_t v, output logic [3:0] exp_st);
        int I, m, T, k, Ae, st, steps;
        bit ab;
        exp_q.delete();
        I  = S;
        ab = 1'b0;
        m  = (v.a > v.b) ? v.a : v.b;
        for (int s = 0; s <= v.end_c; s++) begin
            Ae = (A != 0 && A <= I) ? I + 1 : A;
            if (A != 0 && Ae >= I + 1 && Ae <= I + 8 * v.d) begin
                k = (Ae - I - 1) / v.d;
                T = (k + 1) * v.d; st = 3; steps = k + 1; ab = 1'b1;
            end else if (A != 0 && Ae > I + 8 * v.d && Ae < I + 8 * v.d + m) begin
                T = Ae - I; st = 3; steps = 8; ab = 1'b1;
            end else if (A != 0 && Ae == I + 8 * v.d + m) begin
                T = 8 * v.d + m; st = 2; steps = 8; ab = 1'b1;
            end else begin
                T = 8 * v.d + m; st = 2; steps = 8;
            end
            exp_q.push_back('{s, st, I + T, T, steps});
            if (ab) break;
            I = I + T + 1;
        end
        exp_st = {1'b0, ab, 1'b1, 1'b0};
    endtask

    task automatic run_job(input vec_t v, input bit use_tab);
        int         S, A, n_wb, pos;
        bit         fin_seen, seq_ok;
        logic [3:0] exp_st;
        logic [3:0] ctl;
        ack_d = v.d; dly_a = v.a; dly_b = v.b; early_en = v.early; noise_en = v.noise;
        @(negedge clk);
        ctl    = 4'($urandom);
        ctl[0] = 1'b1;
        ctl[1] = 1'b0;
        control = ctl;
        end_cnt = 3'(v.end_c);
        obs_q.delete();
        seq_q.delete();
        S = cyc + 1;
        A = (v.abort_off != 0) ? S + v.abort_off : 0;
        model(S, A, v, exp_st);
        fin_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (A != 0 && cyc == A - 1) control[1] = 1'b1;
            if (cyc == S) begin
                chk("start_slaveInit", slaveInit, 8'h01);
                chk("start_status", status, 4'b0001);
            end
            if (status[1] === 1'b1) begin fin_seen = 1'b1; break; end
        end
        if (!fin_seen) begin
            n_chk++; n_err++;
            $display("FAIL job_timeout: got no done within 3000 cycles, expected done");
        end
        chk("fin_cycle", cyc, exp_q[exp_q.size() - 1].cyc + 1);
        chk("final_status", status, exp_st);
        chk("wb_count", obs_q.size(), exp_q.size());
        if (use_tab) begin
            chk("tab_status", status, v.exp_status);
            chk("tab_wb_count", obs_q.size(), v.exp_wbs);
        end
        n_wb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n_wb; i++) begin
            chk("wb_slot", obs_q[i].slot, exp_q[i].slot);
            chk("wb_cnt", obs_q[i].cnt, exp_q[i].slot);
            chk("wb_status", obs_q[i].st, exp_q[i].st);
            chk("wb_profile", obs_q[i].prof, exp_q[i].prof);
            chk("wb_cycle", obs_q[i].cyc, exp_q[i].cyc);
        end
        seq_ok = 1'b1;
        pos    = 0;
        foreach (exp_q[i]) begin
            for (int j = 0; j < exp_q[i].steps; j++) begin
                if (pos >= seq_q.size() || seq_q[pos] != (8'h01 << j)) seq_ok = 1'b0;
                pos++;
            end
        end
        if (pos != seq_q.size()) seq_ok = 1'b0;
        chk("step_sequence", seq_ok, 1'b1);
        control = 4'b0000;
        repeat (3) @(negedge clk);
        chk("sticky_status", status, exp_st & 4'b0110);
        chk("idle_slaveInit", slaveInit, 8'h00);
        repeat (30) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"}, status, 4'h0);
        chk({tag, "_cnt"}, cnt_o, 3'h0);
        chk({tag, "_slot_idx"}, slot_idx, 3'h0);
        chk({tag, "_slaveInit"}, slaveInit, 8'h00);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_wr_status"}, wr_status, 2'b00);
        chk({tag, "_wr_profile"}, wr_profile, 32'h0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tab[9];
        vec_t rv;
        int   S, total, m;

        reset = 1'b0; control = '0; end_cnt = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        //          end d  a   b   abort early noise wbs status
        tab[0] = '{0, 4, 10, 10, 0,  1'b0, 1'b0, 1, 4'b0010};
        tab[1] = '{2, 2, 3,  5,  0,  1'b0, 1'b0, 3, 4'b0010};
        tab[2] = '{2, 4, 6,  6,  14, 1'b0, 1'b0, 1, 4'b0110};
        tab[3] = '{1, 2, 5,  5,  21, 1'b0, 1'b0, 1, 4'b0110};
        tab[4] = '{0, 3, 21, 1,  0,  1'b1, 1'b0, 1, 4'b0010};
        tab[5] = '{7, 1, 1,  1,  0,  1'b0, 1'b1, 8, 4'b0010};
        tab[6] = '{3, 1, 8,  8,  11, 1'b0, 1'b0, 1, 4'b0110};
        tab[7] = '{3, 2, 4,  4,  16, 1'b0, 1'b0, 1, 4'b0110};
        tab[8] = '{1, 1, 2,  2,  11, 1'b0, 1'b0, 2, 4'b0110};
        for (int i = 0; i < 9; i++) run_job(tab[i], 1'b1);

        // Reset in the middle of slot 1's config phase, then restart
        ack_d = 1; dly_a = 1; dly_b = 1; early_en = 1'b0; noise_en = 1'b0;
        @(negedge clk);
        control = 4'b0001; end_cnt = 3'd2;
        S = cyc + 1;
        for (int n = 0; n < 100 && cyc < S + 12; n++) @(negedge clk);
        chk("pre_reset_slot", slot_idx, 3'd1);
        chk("pre_reset_slaveInit", slaveInit, 8'h04);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        control = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_job(tab[1], 1'b1);

        // Randomized jobs
        for (int r = 0; r < 25; r++) begin
            rv.end_c = $urandom_range(0, 7);
            rv.d     = $urandom_range(1, 5);
            rv.a     = $urandom_range(1, 12);
            rv.b     = $urandom_range(1, 12);
            m        = (rv.a > rv.b) ? rv.a : rv.b;
            total    = (rv.end_c + 1) * (8 * rv.d + m + 1);
            rv.abort_off  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total) : 0;
            rv.early      = 1'b0;
            rv.noise      = 1'($urandom_range(0, 1));
            rv.exp_wbs    = 0;
            rv.exp_status = 4'b0000;
            run_job(rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
